// File: rtl/uart_echo_buffer.sv
// UART echo engine: FIFO-buffered RX->TX loopback with hold, fill/overflow status.
// Optional ASCII case swap on the TX path when UART_ECHO_CASE_SWAP_EN is defined.
module uart_echo_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_readable,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  output logic                    rx_used_tick,
  output logic                    tx_start,
  output logic [DATA_WIDTH-1:0]   tx_data,
  input  logic                    tx_busy,
  input  logic                    hold,
  input  logic                    clr_ovf,
  output logic [$clog2(DEPTH):0]  fill,
  output logic                    empty,
  output logic                    full,
  output logic                    overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]           fill_q, fill_d;
  logic                    empty_q, empty_d, full_q, full_d;
  logic                    ovf_q, ovf_d;
  logic                    tick_q, tick_d;
  logic                    start_q, start_d;
  logic [DATA_WIDTH-1:0]   txd_q, txd_d;
  logic                    push_req, push_ok, pop;

  function automatic logic [DATA_WIDTH-1:0] tx_map(input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] r;
    r = w;
`ifdef UART_ECHO_CASE_SWAP_EN
    if (DATA_WIDTH == 8) begin
      if ((w >= DATA_WIDTH'(32'h41) && w <= DATA_WIDTH'(32'h5A)) ||
          (w >= DATA_WIDTH'(32'h61) && w <= DATA_WIDTH'(32'h7A)))
        r = w ^ DATA_WIDTH'(32'h20);
    end
`endif
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q && !hold && !tx_busy) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts a word when the head leaves on the same edge.
  always_comb begin
    push_req = rx_readable && !tick_q;
    push_ok  = push_req && (!full_q || pop);
    tick_d   = push_req;
    start_d  = pop;
    txd_d    = pop ? tx_map(mem_q[rd_ptr_q]) : txd_q;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fill_d   = fill_q;
    case ({push_ok, pop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
    empty_d  = (fill_d == '0);
    full_d   = (fill_d == FW'(DEPTH));
    ovf_d    = ovf_q;
    if (push_req && !push_ok) ovf_d = 1'b1;
    else if (clr_ovf)         ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tick_q   <= 1'b0;
      start_q  <= 1'b0;
      txd_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      tick_q   <= tick_d;
      start_q  <= start_d;
      txd_q    <= txd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= rx_data;
  end

  assign rx_used_tick = tick_q;
  assign tx_start     = start_q;
  assign tx_data      = txd_q;
  assign fill         = fill_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Randomized bench for uart_echo_buffer against a queue-based reference model.
module tb_uart_echo_buffer;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_readable = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_used_tick;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_busy = 1'b0;
  logic          hold = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [$clog2(DP):0] fill;
  logic          empty, full, overflow;

  uart_echo_buffer #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .rx_readable(rx_readable), .rx_data(rx_data),
    .rx_used_tick(rx_used_tick), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .hold(hold), .clr_ovf(clr_ovf), .fill(fill),
    .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, transmitter as a cycle count since start.
  int q[$];
  int m_phase  = 0;   // 0 idle, 1 start, 2 guard, 3 waiting for busy to drop
  bit m_tick   = 0;
  bit m_ovf    = 0;
  int m_txdata = 0;

  function automatic int exp_map(input int w);
`ifdef UART_ECHO_CASE_SWAP_EN
    if (DW == 8 && ((w >= 65 && w <= 90) || (w >= 97 && w <= 122))) return w ^ 32;
`endif
    return w;
  endfunction

  task automatic model_step();
    bit push_req, pop, drop;
    int sz;
    if (rst) begin
      q.delete();
      m_phase = 0; m_tick = 0; m_ovf = 0; m_txdata = 0;
      return;
    end
    sz       = q.size();
    push_req = rx_readable && !m_tick;
    pop      = (m_phase == 0) && (sz > 0) && !hold && !tx_busy;
    case (m_phase)
      1: m_phase = 2;
      2: m_phase = 3;
      3: if (!tx_busy) m_phase = 0;
      default: ;
    endcase
    if (pop) begin
      m_txdata = exp_map(q.pop_front());
      m_phase  = 1;
    end
    drop = 0;
    if (push_req) begin
      if (sz < int'(DP) || pop) q.push_back(int'(rx_data));
      else drop = 1;
    end
    if (drop)         m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
    m_tick = push_req;
  endtask

  bit started    = 0;
  bit prev_tick  = 0;
  int busy_cnt   = 0;
  int busy_delay = 0;
  bit saw_full   = 0;
  bit saw_ovf    = 0;

  function automatic logic [DW-1:0] new_word();
    if ($urandom_range(0, 1) == 1) return DW'($urandom_range(32'h41, 32'h7A));
    return DW'($urandom_range(0, 255));
  endfunction

  task automatic run_cycle(input int hold_mode, input int rx_pct, input int busy_max,
                           input int clr_pct, input int rst_pm, input bit force_rst);
    @(negedge clk);
    if (started) begin
      check("rx_used_tick", 32'(rx_used_tick), 32'(m_tick));
      check("tx_start",     32'(tx_start),     32'(m_phase == 1));
      check("tx_data",      32'(tx_data),      m_txdata);
      check("fill",         32'(fill),         q.size());
      check("empty",        32'(empty),        32'(q.size() == 0));
      check("full",         32'(full),         32'(q.size() == int'(DP)));
      check("overflow",     32'(overflow),     32'(m_ovf));
      if (full) saw_full = 1;
      if (overflow) saw_ovf = 1;
    end
    started = 1;
    // RX core: drops or replaces its word once the acknowledge has been sampled
    if (rx_readable && prev_tick) begin
      if (int'($urandom_range(0, 99)) < rx_pct) rx_data = new_word();
      else rx_readable = 1'b0;
    end else if (!rx_readable && int'($urandom_range(0, 99)) < rx_pct) begin
      rx_readable = 1'b1;
      rx_data     = new_word();
    end
    prev_tick = m_tick;
    // TX core: busy begins during the start cycle or the one after
    if (m_phase == 1) begin
      busy_cnt   = $urandom_range(1, busy_max);
      busy_delay = $urandom_range(0, 1);
    end
    if (busy_delay > 0) begin
      busy_delay--;
      tx_busy = 1'b0;
    end else begin
      tx_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end
    case (hold_mode)
      0: hold = 1'b0;
      1: hold = 1'b1;
      default: if ($urandom_range(0, 99) < 5) hold = !hold;
    endcase
    clr_ovf = (int'($urandom_range(0, 99)) < clr_pct);
    rst     = force_rst || (int'($urandom_range(0, 999)) < rst_pm);
    model_step();
  endtask

  initial begin
    for (int i = 0; i < 3; i++)     run_cycle(0, 0, 4, 0, 0, 1'b1);
    for (int i = 0; i < 60; i++)    run_cycle(0, 20, 4, 0, 0, 1'b0);
    for (int i = 0; i < 150; i++)   run_cycle(1, 90, 4, 0, 0, 1'b0);
    for (int i = 0; i < 300; i++)   run_cycle(0, 0, 6, 3, 0, 1'b0);
    for (int i = 0; i < 1500; i++)  run_cycle(2, 60, 3, 2, 4, 1'b0);
    for (int i = 0; i < 400; i++)   run_cycle(0, 80, 20, 1, 0, 1'b0);
    for (int i = 0; i < 400; i++)   run_cycle(2, 70, 8, 2, 8, 1'b0);
    for (int i = 0; i < 400; i++)   run_cycle(0, 0, 4, 0, 0, 1'b0);
    check("saw_full", 32'(saw_full), 32'd1);
    check("saw_overflow", 32'(saw_ovf), 32'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
